// File: rtl/clk_mux_switch_ctrl.sv
// Glitch-free clock mux switch controller.
// A select change is wrapped in two gated phases: DRAIN (clock gated, old
// select still applied) and SETTLE (clock gated, new select applied). The
// mux select therefore only moves while the downstream gate is closed, and
// never on the same edge as the gate opens or closes.
module clk_mux_switch_ctrl #(
  parameter int unsigned SettleCycles = 4,
  parameter logic        ResetSel     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic sel_req_i,
  output logic sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic ack_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  // Phase length minus one: the counter is checked for zero before it
  // decrements, so loading N-1 yields exactly N cycles per phase.
  localparam logic [7:0] CNT_LOAD = 8'(SettleCycles - 1);

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_sel_lat;
  logic       r_sel;
  logic       r_clk_en;
  logic       r_busy;
  logic       r_ack;

  logic [1:0] w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_sel_lat_nxt;
  logic       w_sel_nxt;
  logic       w_clk_en_nxt;
  logic       w_busy_nxt;
  logic       w_ack_nxt;
  logic       w_cnt_zero;
  logic [7:0] w_cnt_dec;

  assign w_cnt_zero = (r_cnt == 8'd0);
  // Saturating decrement: the counter never wraps below zero.
  assign w_cnt_dec  = w_cnt_zero ? 8'd0 : (r_cnt - 8'd1);

  // Next-state and next-output decode; every output is then registered so
  // no input reaches an output without passing through a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sel_lat_nxt = r_sel_lat;
    w_sel_nxt     = r_sel;
    w_clk_en_nxt  = r_clk_en;
    w_busy_nxt    = r_busy;
    w_ack_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clk_en_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
        if (req_i) begin
          if (sel_req_i != r_sel) begin
            // Real switch: close the gate first, select moves later.
            w_sel_lat_nxt = sel_req_i;
            w_cnt_nxt     = CNT_LOAD;
            w_state_nxt   = ST_DRAIN;
            w_clk_en_nxt  = 1'b0;
            w_busy_nxt    = 1'b1;
          end else begin
            // Already on the requested source: acknowledge immediately.
            w_ack_nxt = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        w_clk_en_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
        if (w_cnt_zero) begin
          // Gate has been closed long enough; flip the mux now.
          w_state_nxt = ST_SETTLE;
          w_sel_nxt   = r_sel_lat;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      ST_SETTLE: begin
        w_clk_en_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
        if (w_cnt_zero) begin
          // New source has settled; reopen the gate and report completion.
          w_state_nxt  = ST_IDLE;
          w_clk_en_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
          w_ack_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = 8'd0;
        w_clk_en_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  // Control state and output flops; reset aborts any sequence in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_sel    <= ResetSel;
      r_clk_en <= 1'b1;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_busy   <= w_busy_nxt;
      r_ack    <= w_ack_nxt;
    end
  end

  // Latched target select; only meaningful once a switch has been accepted.
  always_ff @(posedge clk_i) begin
    r_sel_lat <= w_sel_lat_nxt;
  end

  assign sel_o    = r_sel;
  assign clk_en_o = r_clk_en;
  assign busy_o   = r_busy;
  assign ack_o    = r_ack;

endmodule

// File: doc/clk_mux_switch_ctrl.md
CLK_MUX_SWITCH_CTRL -- requirements
Module: clk_mux_switch_ctrl

Interface
REQ-001 Parameter SettleCycles, default 4, SHALL set the number of cycles for each gated phase (drain and settle); the legal range SHALL be 1..255.
REQ-002 Parameter ResetSel, default 1'b0, SHALL set the mux select value applied during and after reset.
REQ-003 Port clk_i, input, 1 bit: the single controller clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req_i, input, 1 bit: switch request, sampled only in IDLE.
REQ-006 Port sel_req_i, input, 1 bit: requested select, captured with req_i.
REQ-007 Port sel_o, output, 1 bit: registered select driven to the two-input clock mux.
REQ-008 Port clk_en_o, output, 1 bit: registered enable to the downstream clock gate; 1 means the muxed clock may propagate.
REQ-009 Port busy_o, output, 1 bit: high while a switch sequence is in progress.
REQ-010 Port ack_o, output, 1 bit: single-cycle completion pulse for an accepted request.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, DRAIN and SETTLE.
REQ-012 The block SHALL use one 8-bit down-counter, shared by DRAIN and SETTLE.
REQ-013 In IDLE: clk_en_o=1 and busy_o=0.
REQ-014 In IDLE, a cycle with req_i=1 and sel_req_i!=sel_o SHALL accept the request: sel_req_i is latched, the counter loads SettleCycles-1, and the next state is DRAIN.
REQ-015 In IDLE, a cycle with req_i=1 and sel_req_i==sel_o SHALL drive ack_o=1 in the next cycle only, with no state change, no gating, and busy_o held at 0.
REQ-016 DRAIN: clk_en_o=0, busy_o=1, sel_o unchanged, and the counter decrements each cycle.
REQ-017 When the counter is 0 in DRAIN, the next state SHALL be SETTLE, sel_o SHALL take the latched value on that same edge, and the counter SHALL reload SettleCycles-1.
REQ-018 SETTLE: clk_en_o=0, busy_o=1, and the counter decrements each cycle.
REQ-019 When the counter is 0 in SETTLE, the next state SHALL be IDLE, with clk_en_o=1 and ack_o=1 on the first IDLE cycle.
REQ-020 Timing for a request sampled at edge t with N=SettleCycles:
- clk_en_o=0 for cycles t+1..t+2N
- sel_o takes the new value from cycle t+N+1
- ack_o=1 and clk_en_o=1 in cycle t+2N+1
- busy_o=1 for cycles t+1..t+2N
REQ-021 In DRAIN and SETTLE, req_i and sel_req_i SHALL be ignored; no queuing and no ack for ignored requests.
REQ-022 The ack_o cycle is an IDLE cycle, so a request present in that cycle SHALL be accepted per REQ-014/REQ-015; back-to-back switches are allowed.
REQ-023 sel_o SHALL never change while clk_en_o=1.
REQ-024 sel_o SHALL never change in the same cycle that clk_en_o changes.
REQ-025 ack_o SHALL never be high for two consecutive cycles unless a new request was accepted in the first of them.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-027 Counter arithmetic SHALL be 8-bit unsigned; the counter SHALL NOT decrement below 0.

Reset
REQ-028 While rst_i=1 at a clock edge, the block SHALL set: state=IDLE, sel_o=ResetSel, clk_en_o=1, busy_o=0, ack_o=0, counter=0.
REQ-029 A reset asserted in DRAIN or SETTLE SHALL abort the sequence: no ack_o, and sel_o returns to ResetSel even if it had already switched.
REQ-030 A request present in the first cycle after rst_i deasserts SHALL be accepted normally.

Verification
REQ-031 Scenario, N=4, ResetSel=0: req_i=1, sel_req_i=1 sampled at t -> clk_en_o=0 over t+1..t+8, sel_o=1 from t+5, ack_o=1 only at t+9, busy_o=1 over t+1..t+8.
REQ-032 Scenario, same-select: sel_o=0, req_i=1, sel_req_i=0 -> ack_o=1 next cycle only; clk_en_o stays 1, busy_o stays 0, sel_o stays 0.
REQ-033 Scenario, ignored request: during DRAIN of a 0->1 switch, toggle req_i and sel_req_i every cycle -> timing identical to REQ-031, final sel_o=1, exactly one ack_o.
REQ-034 Scenario, reset mid-sequence: rst_i=1 at cycle t+6 of a 0->1 switch, i.e. in SETTLE -> next cycle sel_o=0, clk_en_o=1, busy_o=0; no ack_o ever issued for that request.
REQ-035 Scenario, N=1 back-to-back: req_i held high, sel_req_i=1 then 0 -> ack_o at t+3, second request accepted at t+3, ack_o at t+6, sel_o sequence 0,0,1,1,1,0.
REQ-036 Checker, whole run: flag any cycle where sel_o changes while clk_en_o=1 in the previous or current cycle.
